// File: rtl/cs_seq_pkg.sv
// Shared definitions for the control-store micro-op sequencer: one-hot state
// encodings, default widths and the held-flag bundle.
package cs_seq_pkg;

  localparam int CTRL_W_DEF = 230;
  localparam int ITER_W_DEF = 16;

  typedef logic [4:0] state_t;

  localparam int ST_IDLE_B  = 0;
  localparam int ST_U0_B    = 1;
  localparam int ST_U1_B    = 2;
  localparam int ST_REPW_B  = 3;
  localparam int ST_FAULT_B = 4;

  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_U0    = 5'b00010;
  localparam logic [4:0] ST_U1    = 5'b00100;
  localparam logic [4:0] ST_REPW  = 5'b01000;
  localparam logic [4:0] ST_FAULT = 5'b10000;

  typedef struct packed {
    logic dbl;
    logic rep;
  } uop_flags_t;

  // REP instructions check the iteration count before issuing anything.
  function automatic state_t capture_state(input logic cs_hit, input logic is_rep);
    if (!cs_hit) return ST_FAULT;
    if (is_rep) return ST_REPW;
    return ST_U0;
  endfunction

endpackage

// File: rtl/cs_uop_hold_reg.sv
// Holds the accepted instruction (control vector plus double/REP flags) for
// the whole time the sequencer is issuing its micro-ops.
module cs_uop_hold_reg
  import cs_seq_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_load,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  uop_flags_t        i_flags,
  output logic [CTRL_W-1:0] o_ctrl,
  output uop_flags_t        o_flags
);

  logic [CTRL_W-1:0] r_ctrl;
  uop_flags_t        r_flags;

  // NOTE: the wide control register is reset too, so out_ctrl reads zero out of reset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_ctrl  <= '0;
      r_flags <= '0;
    end else if (i_load) begin
      r_ctrl  <= i_ctrl;
      r_flags <= i_flags;
    end
  end

  assign o_ctrl  = r_ctrl;
  assign o_flags = r_flags;

endmodule

// File: rtl/cs_uop_sequencer.sv
// Issues each decoded instruction as one or two micro-ops, loops REP
// instructions under execution-stage control and holds a fault on a CS miss.
module cs_uop_sequencer
  import cs_seq_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int ITER_W = ITER_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_cs_hit,
  input  logic              in_isDouble,
  input  logic              in_isREP,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              uop_idx,
  output logic              last_uop,
  output logic              rep_query,
  input  logic              rep_resolve,
  input  logic              rep_continue,
  output logic [ITER_W-1:0] rep_iter,
  output logic              cs_fault,
  input  logic              fault_ack
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ITER_W-1:0] r_rep_iter;
  logic [CTRL_W-1:0] w_held_ctrl;
  uop_flags_t        w_in_flags;
  uop_flags_t        w_held_flags;

  logic w_in_idle, w_in_u0, w_in_u1, w_in_repw, w_in_fault;
  logic w_out_hs, w_capture, w_iter_done;

  assign w_in_idle  = r_state[ST_IDLE_B];
  assign w_in_u0    = r_state[ST_U0_B];
  assign w_in_u1    = r_state[ST_U1_B];
  assign w_in_repw  = r_state[ST_REPW_B];
  assign w_in_fault = r_state[ST_FAULT_B];

  assign out_valid = w_in_u0 | w_in_u1;
  assign uop_idx   = w_in_u1;
  assign last_uop  = w_in_u1 | (w_in_u0 & ~w_held_flags.dbl);
  assign rep_query = w_in_repw;
  assign cs_fault  = w_in_fault;
  assign out_ctrl  = w_held_ctrl;
  assign rep_iter  = r_rep_iter;

  assign w_out_hs    = out_valid & out_ready;
  assign w_iter_done = w_out_hs & last_uop & w_held_flags.rep;

  // Accept the next instruction in the same cycle the last uop of a non-REP one leaves.
  assign in_ready  = ~flush & (w_in_idle | (w_out_hs & last_uop & ~w_held_flags.rep));
  assign w_capture = in_valid & in_ready;

  assign w_in_flags.dbl = in_isDouble;
  assign w_in_flags.rep = in_isREP;

  cs_uop_hold_reg #(
    .CTRL_W (CTRL_W)
  ) u_hold (
    .clk     (clk),
    .clr     (clr),
    .i_load  (w_capture),
    .i_ctrl  (in_ctrl),
    .i_flags (w_in_flags),
    .o_ctrl  (w_held_ctrl),
    .o_flags (w_held_flags)
  );

  // NOTE: w_state_nxt gets a default first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_capture) w_state_nxt = capture_state(in_cs_hit, in_isREP);
        end
        ST_U0: begin
          if (w_out_hs) begin
            if (w_held_flags.dbl)      w_state_nxt = ST_U1;
            else if (w_held_flags.rep) w_state_nxt = ST_REPW;
            else if (w_capture)        w_state_nxt = capture_state(in_cs_hit, in_isREP);
            else                       w_state_nxt = ST_IDLE;
          end
        end
        ST_U1: begin
          if (w_out_hs) begin
            if (w_held_flags.rep) w_state_nxt = ST_REPW;
            else if (w_capture)   w_state_nxt = capture_state(in_cs_hit, in_isREP);
            else                  w_state_nxt = ST_IDLE;
          end
        end
        ST_REPW: begin
          if (rep_resolve) w_state_nxt = rep_continue ? ST_U0 : ST_IDLE;
        end
        ST_FAULT: begin
          if (fault_ack) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Counts completed iterations; saturates rather than wrapping to zero.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_rep_iter <= '0;
    end else if (flush || w_capture) begin
      r_rep_iter <= '0;
    end else if (w_iter_done && (r_rep_iter != '1)) begin
      r_rep_iter <= r_rep_iter + ITER_W'(1);
    end
  end

endmodule

// File: tb/tb_cs_uop_sequencer.sv
// Directed bench for cs_uop_sequencer: single/double issue, REP looping,
// CS-miss fault, flush and asynchronous reset.
module tb_cs_uop_sequencer;

  localparam int CW = 230;
  localparam int IW = 16;

  localparam logic [CW-1:0] CA = {2'b10, 196'h0, 32'hA0A0_0001};
  localparam logic [CW-1:0] CB = {2'b01, 196'h5, 32'hB0B0_0002};
  localparam logic [CW-1:0] CC = {2'b11, 196'h0, 32'hC0C0_0003};
  localparam logic [CW-1:0] CD = {2'b00, 196'h9, 32'hD0D0_0004};
  localparam logic [CW-1:0] CE = {2'b10, 196'h3, 32'hE0E0_0005};
  localparam logic [CW-1:0] CF = {2'b01, 196'h0, 32'hF0F0_0006};
  localparam logic [CW-1:0] CG = {2'b11, 196'h7, 32'h1111_0007};
  localparam logic [CW-1:0] CH = {2'b00, 196'h0, 32'h2222_0008};

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          flush, in_valid, in_cs_hit, in_isDouble, in_isREP;
  logic [CW-1:0] in_ctrl;
  logic          out_ready, rep_resolve, rep_continue, fault_ack;
  logic          in_ready, out_valid, uop_idx, last_uop, rep_query, cs_fault;
  logic [CW-1:0] out_ctrl;
  logic [IW-1:0] rep_iter;

  // {out_valid, uop_idx, last_uop, in_ready, rep_query, cs_fault}
  logic [5:0] w_st;
  assign w_st = {out_valid, uop_idx, last_uop, in_ready, rep_query, cs_fault};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cs_uop_sequencer #(.CTRL_W(CW), .ITER_W(IW)) dut (
    .clk          (clk),
    .clr          (clr),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_cs_hit    (in_cs_hit),
    .in_isDouble  (in_isDouble),
    .in_isREP     (in_isREP),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .uop_idx      (uop_idx),
    .last_uop     (last_uop),
    .rep_query    (rep_query),
    .rep_resolve  (rep_resolve),
    .rep_continue (rep_continue),
    .rep_iter     (rep_iter),
    .cs_fault     (cs_fault),
    .fault_ack    (fault_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    flush = 0; in_valid = 0; in_ctrl = '0; in_cs_hit = 0; in_isDouble = 0; in_isREP = 0;
    out_ready = 1; rep_resolve = 0; rep_continue = 0; fault_ack = 0;
    #2 clr = 1'b0;
    #1;
    n_vec++; if (w_st !== 6'b000100) begin n_err++; $display("FAIL reset_st got=%b exp=%b", w_st, 6'b000100); end
    n_vec++; if (rep_iter !== '0) begin n_err++; $display("FAIL reset_iter got=%0d exp=0", rep_iter); end
    n_vec++; if (out_ctrl !== '0) begin n_err++; $display("FAIL reset_ctrl got=%h exp=0", out_ctrl); end
    step();
    clr = 1'b1;
    #1;
    n_vec++; if (w_st !== 6'b000100) begin n_err++; $display("FAIL reset_release_st got=%b exp=%b", w_st, 6'b000100); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1; in_ctrl = CA; in_cs_hit = 1; in_isDouble = 0; in_isREP = 0; out_ready = 1;
    #1;
    n_vec++; if (w_st !== 6'b000100) begin n_err++; $display("FAIL b2b_idle_st got=%b exp=%b", w_st, 6'b000100); end
    step();
    in_ctrl = CB;
    #1;
    n_vec++; if (w_st !== 6'b101100) begin n_err++; $display("FAIL b2b_a_st got=%b exp=%b", w_st, 6'b101100); end
    n_vec++; if (out_ctrl !== CA) begin n_err++; $display("FAIL b2b_a_ctrl got=%h exp=%h", out_ctrl, CA); end
    step();
    in_valid = 0;
    #1;
    n_vec++; if (w_st !== 6'b101100) begin n_err++; $display("FAIL b2b_b_st got=%b exp=%b", w_st, 6'b101100); end
    n_vec++; if (out_ctrl !== CB) begin n_err++; $display("FAIL b2b_b_ctrl got=%h exp=%h", out_ctrl, CB); end
    step();
    n_vec++; if (w_st !== 6'b000100) begin n_err++; $display("FAIL b2b_end_st got=%b exp=%b", w_st, 6'b000100); end
  endtask

  task automatic test_double();
    in_valid = 1; in_ctrl = CC; in_cs_hit = 1; in_isDouble = 1; in_isREP = 0; out_ready = 1;
    step();
    in_ctrl = CD; in_isDouble = 0;
    #1;
    n_vec++; if (w_st !== 6'b100000) begin n_err++; $display("FAIL dbl_u0_st got=%b exp=%b", w_st, 6'b100000); end
    n_vec++; if (out_ctrl !== CC) begin n_err++; $display("FAIL dbl_u0_ctrl got=%h exp=%h", out_ctrl, CC); end
    step();
    out_ready = 0;
    #1;
    n_vec++; if (w_st !== 6'b111000) begin n_err++; $display("FAIL dbl_u1_st got=%b exp=%b", w_st, 6'b111000); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (w_st !== 6'b111000) begin n_err++; $display("FAIL dbl_stall%0d_st got=%b exp=%b", i, w_st, 6'b111000); end
      n_vec++; if (out_ctrl !== CC) begin n_err++; $display("FAIL dbl_stall%0d_ctrl got=%h exp=%h", i, out_ctrl, CC); end
    end
    out_ready = 1;
    #1;
    n_vec++; if (w_st !== 6'b111100) begin n_err++; $display("FAIL dbl_u1_hs_st got=%b exp=%b", w_st, 6'b111100); end
    step();
    in_valid = 0;
    #1;
    n_vec++; if (w_st !== 6'b101100) begin n_err++; $display("FAIL dbl_next_st got=%b exp=%b", w_st, 6'b101100); end
    n_vec++; if (out_ctrl !== CD) begin n_err++; $display("FAIL dbl_next_ctrl got=%h exp=%h", out_ctrl, CD); end
    step();
    n_vec++; if (w_st !== 6'b000100) begin n_err++; $display("FAIL dbl_end_st got=%b exp=%b", w_st, 6'b000100); end
  endtask

  task automatic test_rep();
    logic          cont[3];
    logic [IW-1:0] exp_iter[3];
    int            n_uops;
    cont = '{1'b1, 1'b1, 1'b0};
    exp_iter = '{16'd1, 16'd2, 16'd2};
    n_uops = 0;
    in_valid = 1; in_ctrl = CE; in_cs_hit = 1; in_isDouble = 0; in_isREP = 1; out_ready = 1;
    step();
    in_valid = 0; in_isREP = 0;
    #1;
    n_vec++; if (w_st !== 6'b000010) begin n_err++; $display("FAIL rep_first_st got=%b exp=%b", w_st, 6'b000010); end
    n_vec++; if (rep_iter !== 16'd0) begin n_err++; $display("FAIL rep_first_iter got=%0d exp=0", rep_iter); end
    for (int k = 0; k < 3; k++) begin
      rep_resolve = 0; rep_continue = ~cont[k];
      step();
      n_uops += int'(out_valid);
      n_vec++; if (w_st !== 6'b000010) begin n_err++; $display("FAIL rep_wait%0d_st got=%b exp=%b", k, w_st, 6'b000010); end
      rep_resolve = 1; rep_continue = cont[k];
      step();
      rep_resolve = 0; rep_continue = 0;
      n_uops += int'(out_valid);
      if (cont[k]) begin
        n_vec++; if (w_st !== 6'b101000) begin n_err++; $display("FAIL rep_uop%0d_st got=%b exp=%b", k, w_st, 6'b101000); end
        n_vec++; if (out_ctrl !== CE) begin n_err++; $display("FAIL rep_uop%0d_ctrl got=%h exp=%h", k, out_ctrl, CE); end
        step();
        n_uops += int'(out_valid);
        n_vec++; if (w_st !== 6'b000010) begin n_err++; $display("FAIL rep_back%0d_st got=%b exp=%b", k, w_st, 6'b000010); end
      end else begin
        n_vec++; if (w_st !== 6'b000100) begin n_err++; $display("FAIL rep_done_st got=%b exp=%b", w_st, 6'b000100); end
      end
      n_vec++; if (rep_iter !== exp_iter[k]) begin n_err++; $display("FAIL rep_iter%0d got=%0d exp=%0d", k, rep_iter, exp_iter[k]); end
    end
    n_vec++; if (n_uops != 2) begin n_err++; $display("FAIL rep_uop_count got=%0d exp=2", n_uops); end
  endtask

  task automatic test_rep_zero();
    in_valid = 1; in_ctrl = CF; in_cs_hit = 1; in_isDouble = 0; in_isREP = 1; out_ready = 1;
    step();
    in_valid = 0; in_isREP = 0;
    #1;
    n_vec++; if (w_st !== 6'b000010) begin n_err++; $display("FAIL rep0_query_st got=%b exp=%b", w_st, 6'b000010); end
    n_vec++; if (rep_iter !== 16'd0) begin n_err++; $display("FAIL rep0_clear_iter got=%0d exp=0", rep_iter); end
    rep_resolve = 1; rep_continue = 0;
    step();
    rep_resolve = 0;
    n_vec++; if (w_st !== 6'b000100) begin n_err++; $display("FAIL rep0_end_st got=%b exp=%b", w_st, 6'b000100); end
    n_vec++; if (rep_iter !== 16'd0) begin n_err++; $display("FAIL rep0_end_iter got=%0d exp=0", rep_iter); end
  endtask

  task automatic test_fault();
    in_valid = 1; in_ctrl = CG; in_cs_hit = 0; in_isDouble = 0; in_isREP = 0; out_ready = 1;
    step();
    in_ctrl = CH; in_cs_hit = 1;
    #1;
    n_vec++; if (w_st !== 6'b000001) begin n_err++; $display("FAIL fault_set_st got=%b exp=%b", w_st, 6'b000001); end
    step();
    n_vec++; if (w_st !== 6'b000001) begin n_err++; $display("FAIL fault_hold_st got=%b exp=%b", w_st, 6'b000001); end
    fault_ack = 1;
    #1;
    n_vec++; if (w_st !== 6'b000001) begin n_err++; $display("FAIL fault_ack_cycle_st got=%b exp=%b", w_st, 6'b000001); end
    step();
    fault_ack = 0;
    #1;
    n_vec++; if (w_st !== 6'b000100) begin n_err++; $display("FAIL fault_clear_st got=%b exp=%b", w_st, 6'b000100); end
    step();
    in_valid = 0;
    #1;
    n_vec++; if (w_st !== 6'b101100) begin n_err++; $display("FAIL fault_next_st got=%b exp=%b", w_st, 6'b101100); end
    n_vec++; if (out_ctrl !== CH) begin n_err++; $display("FAIL fault_next_ctrl got=%h exp=%h", out_ctrl, CH); end
    step();
  endtask

  task automatic test_flush();
    in_valid = 1; in_ctrl = CA; in_cs_hit = 1; in_isDouble = 1; in_isREP = 0; out_ready = 1;
    step();
    in_valid = 0; in_isDouble = 0;
    step();
    flush = 1;
    #1;
    n_vec++; if (w_st !== 6'b111000) begin n_err++; $display("FAIL flush_u1_st got=%b exp=%b", w_st, 6'b111000); end
    step();
    flush = 0;
    #1;
    n_vec++; if (w_st !== 6'b000100) begin n_err++; $display("FAIL flush_u1_after_st got=%b exp=%b", w_st, 6'b000100); end
    in_valid = 1; in_ctrl = CB; flush = 1;
    #1;
    n_vec++; if (w_st !== 6'b000000) begin n_err++; $display("FAIL flush_cap_st got=%b exp=%b", w_st, 6'b000000); end
    step();
    flush = 0; in_valid = 0;
    #1;
    n_vec++; if (w_st !== 6'b000100) begin n_err++; $display("FAIL flush_cap_drop_st got=%b exp=%b", w_st, 6'b000100); end
    in_valid = 1; in_ctrl = CE; in_isREP = 1;
    step();
    in_valid = 0; in_isREP = 0; rep_resolve = 1; rep_continue = 1;
    step();
    rep_resolve = 0; rep_continue = 0;
    step();
    n_vec++; if (rep_iter !== 16'd1) begin n_err++; $display("FAIL flush_repw_pre_iter got=%0d exp=1", rep_iter); end
    flush = 1; rep_resolve = 1; rep_continue = 1;
    step();
    flush = 0; rep_resolve = 0; rep_continue = 0;
    #1;
    n_vec++; if (w_st !== 6'b000100) begin n_err++; $display("FAIL flush_repw_st got=%b exp=%b", w_st, 6'b000100); end
    n_vec++; if (rep_iter !== 16'd0) begin n_err++; $display("FAIL flush_repw_iter got=%0d exp=0", rep_iter); end
  endtask

  task automatic test_clr_repw();
    in_valid = 1; in_ctrl = CD; in_cs_hit = 1; in_isDouble = 0; in_isREP = 1; out_ready = 1;
    step();
    in_valid = 0; in_isREP = 0; rep_resolve = 1; rep_continue = 1;
    step();
    rep_resolve = 0; rep_continue = 0;
    step();
    #1;
    n_vec++; if (w_st !== 6'b000010) begin n_err++; $display("FAIL clr_pre_st got=%b exp=%b", w_st, 6'b000010); end
    n_vec++; if (rep_iter !== 16'd1) begin n_err++; $display("FAIL clr_pre_iter got=%0d exp=1", rep_iter); end
    clr = 1'b0;
    #1;
    n_vec++; if (w_st !== 6'b000100) begin n_err++; $display("FAIL clr_st got=%b exp=%b", w_st, 6'b000100); end
    n_vec++; if (rep_iter !== 16'd0) begin n_err++; $display("FAIL clr_iter got=%0d exp=0", rep_iter); end
    n_vec++; if (out_ctrl !== '0) begin n_err++; $display("FAIL clr_ctrl got=%h exp=0", out_ctrl); end
    step();
    clr = 1'b1;
    #1;
    n_vec++; if (w_st !== 6'b000100) begin n_err++; $display("FAIL clr_release_st got=%b exp=%b", w_st, 6'b000100); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_double();
    test_rep();
    test_rep_zero();
    test_fault();
    test_flush();
    test_clr_repw();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cs_uop_sequencer.md
Name: cs_uop_sequencer

Overview:
- Sits between the control-store decode output and the operand/register-read stage.
- Takes one decoded instruction per handshake: the control vector, cs_hit, isDouble and isREP.
- Issues that instruction downstream as one or two micro-ops; holds upstream while it does so.
- Loops the micro-op sequence for REP-prefixed instructions under execution-stage feedback, and raises a held fault on a control-store miss.

Parameters:
- CTRL_W, 230: width of the decoded control vector carried per micro-op.
- ITER_W, 16: width of the REP iteration counter.

Ports:
- clk  in  1  clock.
- clr  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  decoded instruction available.
- in_ready  out  1  sequencer accepts the instruction this cycle.
- in_ctrl  in  CTRL_W  decoded control vector.
- in_cs_hit  in  1  control-store lookup hit.
- in_isDouble  in  1  instruction needs two micro-ops.
- in_isREP  in  1  REP prefix present.
- out_valid  out  1  micro-op valid.
- out_ready  in  1  downstream accepts the micro-op.
- out_ctrl  out  CTRL_W  held control vector.
- uop_idx  out  1  0 = first micro-op, 1 = second micro-op.
- last_uop  out  1  final micro-op of the current iteration.
- rep_query  out  1  requesting the ECX/termination decision.
- rep_resolve  in  1  decision valid.
- rep_continue  in  1  1 = run another iteration, 0 = terminate.
- rep_iter  out  ITER_W  completed-iteration count of the current REP instruction.
- cs_fault  out  1  control-store miss pending.
- fault_ack  in  1  fault serviced.

Behaviour:
- Reset (clr=0, async):
  - state=IDLE; out_valid=0, uop_idx=0, last_uop=0, rep_query=0, cs_fault=0; rep_iter=0; held registers=0.
- States: IDLE, U0, U1, REPW, FAULT. State encoding is one-hot.
- in_ready:
  - 1 in IDLE.
  - 1 in U0/U1 when out_valid & out_ready & last_uop & !held_rep (zero-bubble back-to-back).
  - 0 otherwise, and 0 whenever flush=1.
- Capture (in_valid & in_ready):
  - Latch in_ctrl, in_isDouble, in_isREP; clear rep_iter.
  - Next state: !in_cs_hit -> FAULT; else in_isREP -> REPW (the zero-count check precedes the first iteration); else -> U0.
- U0:
  - out_valid=1, uop_idx=0, last_uop=!held_dbl.
  - On handshake: held_dbl -> U1; else held_rep -> REPW; else -> IDLE, or capture if in_valid.
- U1:
  - out_valid=1, uop_idx=1, last_uop=1.
  - On handshake: held_rep -> REPW; else -> IDLE, or capture if in_valid.
- REPW entered after an iteration's last uop: rep_iter increments, saturating at all-ones.
- REPW:
  - rep_query=1, out_valid=0.
  - rep_resolve & rep_continue -> U0.
  - rep_resolve & !rep_continue -> IDLE.
  - Stays in REPW while rep_resolve=0.
  - rep_continue is ignored without rep_resolve.
- FAULT:
  - cs_fault=1, out_valid=0, in_ready=0.
  - fault_ack -> IDLE; cs_fault drops the cycle after the ack.
- out_ctrl is registered and stable while out_valid=1 and out_ready=0 (no change under backpressure).
- flush:
  - From any state: next state=IDLE; rep_iter=0.
  - Beats capture in the same cycle; the instruction is dropped and in_ready=0 that cycle.
  - Beats rep_resolve and fault_ack in the same cycle.
- Latency: capture to first out_valid is 1 cycle (U0, or REPW for REP).
- Steady-state throughput: 1 single-uop instruction per cycle.

Decomposition:
- Shared package cs_seq_pkg: state encodings (IDLE/U0/U1/REPW/FAULT one-hot constants) and the CTRL_W default.
- One sub-module, cs_uop_hold_reg: an enable-loaded register bundle for ctrl/dbl/rep with async clr.
- The FSM and counter stay in cs_uop_sequencer.

Test Plan:
- Single uop, out_ready=1, in_valid held with ctrl=A then B, isDouble=0 -> out_valid each cycle from cycle 1; out_ctrl=A then B; last_uop=1; in_ready=1 every cycle.
- Double uop, ctrl=C, out_ready low for 3 cycles in U1 -> uop_idx 0 then 1; out_ctrl=C steady through the stall; in_ready=0 until U1 handshake.
- REP single uop; rep_continue pattern 1,1,0, each with rep_resolve one cycle after rep_query -> exactly 2 uops issued; rep_iter ends at 2; return to IDLE.
- REP with first decision rep_continue=0 -> zero uops issued; rep_iter=0.
- in_cs_hit=0 -> cs_fault=1 from the next cycle; in_ready=0; after fault_ack, cs_fault=0 and the next instruction is accepted.
- flush asserted mid-U1 of a double and during a capture cycle; clr pulsed mid-REPW -> IDLE; outputs zero; captured instruction dropped; rep_iter=0.
